// File: rtl/mux_logic_pkg.sv
// Shared op encoding and widths for the mux-built logic unit.
package mux_logic_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/mux_logic_unit_mux2.sv
// Single-bit 2:1 mux: the only primitive the logic unit datapath is built from.
module mux2 (
    input  logic sel,
    input  logic d1,
    input  logic d0,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_unit.sv
// Two-stage handshaked bitwise logic unit with an optional accumulate mode.
module mux_logic_unit
    import mux_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [CNT_W-1:0] out_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [OP_W-1:0]  s1_op_bits;
    logic             s1_acc_en;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res;
    logic             s2_adv;
    logic             s1_adv;
    logic             s2_load;

    // Combinational ready chain so a full pipeline still moves one beat per cycle.
    assign s2_adv     = !out_valid || out_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign s2_load    = s2_adv && s1_valid;
    assign in_ready   = s1_adv;
    assign s1_op_bits = s1_op;

    // S1: operand capture on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_AND;
            s1_acc_en <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= in1;
                s1_b      <= in2;
                s1_op     <= op_e'(op);
                s1_acc_en <= acc_en;
            end
        end
    end

    // Per-bit gate cells and op-select tree, all from mux2.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        logic b, not_a, and_y, or_y, nand_y, nor_y, xor_y, xnor_y;
        logic m0, m1, m2, m3, n0, n1;

        mux2 u_bsel (.sel(s1_acc_en), .d1(acc[i]),  .d0(s1_b[i]), .y(b));
        mux2 u_not  (.sel(s1_a[i]),   .d1(1'b0),    .d0(1'b1),    .y(not_a));
        mux2 u_and  (.sel(b),         .d1(s1_a[i]), .d0(1'b0),    .y(and_y));
        mux2 u_or   (.sel(s1_a[i]),   .d1(1'b1),    .d0(b),       .y(or_y));
        mux2 u_nand (.sel(and_y),     .d1(1'b0),    .d0(1'b1),    .y(nand_y));
        mux2 u_nor  (.sel(or_y),      .d1(1'b0),    .d0(1'b1),    .y(nor_y));
        mux2 u_xor  (.sel(b),         .d1(not_a),   .d0(s1_a[i]), .y(xor_y));
        mux2 u_xnor (.sel(b),         .d1(s1_a[i]), .d0(not_a),   .y(xnor_y));

        mux2 u_m0 (.sel(s1_op_bits[0]), .d1(or_y),    .d0(and_y),  .y(m0));
        mux2 u_m1 (.sel(s1_op_bits[0]), .d1(nand_y),  .d0(not_a),  .y(m1));
        mux2 u_m2 (.sel(s1_op_bits[0]), .d1(xor_y),   .d0(nor_y),  .y(m2));
        mux2 u_m3 (.sel(s1_op_bits[0]), .d1(s1_a[i]), .d0(xnor_y), .y(m3));
        mux2 u_n0 (.sel(s1_op_bits[1]), .d1(m1),      .d0(m0),     .y(n0));
        mux2 u_n1 (.sel(s1_op_bits[1]), .d1(m3),      .d0(m2),     .y(n1));
        mux2 u_y  (.sel(s1_op_bits[2]), .d1(n1),      .d0(n0),     .y(res[i]));
    end

    // S2: result register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out1      <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s2_load) begin
                out1 <= res;
            end
        end
    end

    // Accumulator tracks the last result loaded; a load outranks a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (s2_load) begin
            acc <= res;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Completed-handoff counter, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule
